mem_stage: RTL and testbench

- Consumer end of the EX/MEM interface. Takes the registered EX/MEM bundle and performs the data-memory load or store over a variable-latency req/ack port.
- Stalls upstream while a memory access is outstanding.
- Produces the registered MEM/WB bundle for writeback.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: consumer end of the EX/MEM interface.
// Issues the data-memory load/store on a variable-latency req/ack port,
// stalls upstream while an access is outstanding, aborts after
// TIMEOUT_CYCLES wait cycles and produces the registered MEM/WB bundle.
// Optional feature macro: MEM_ALIGN_CHECK_EN (rejects misaligned memops).
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [74:0] ex_mem_bundle,
   input  logic        ex_mem_valid,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [70:0] mem_wb_bundle,
   output logic        mem_wb_valid,
   output logic        mem_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // Last counter value before an outstanding access is abandoned.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   // EX/MEM field decode
   logic        mem_read_s;
   logic        mem_write_s;
   logic        reg_write_s;
   logic        mem_to_reg_s;
   logic [31:0] alu_result_s;
   logic [31:0] store_data_s;
   logic [4:0]  reg_dest_s;
   logic        unused_bits_s;

   assign mem_read_s    = ex_mem_bundle[73];
   assign mem_write_s   = ex_mem_bundle[72];
   assign reg_write_s   = ex_mem_bundle[71];
   assign mem_to_reg_s  = ex_mem_bundle[70];
   assign alu_result_s  = ex_mem_bundle[69:38];
   assign store_data_s  = ex_mem_bundle[36:5];
   assign reg_dest_s    = ex_mem_bundle[4:0];
   // branch and zero flags have no meaning in this stage
   assign unused_bits_s = ex_mem_bundle[74] ^ ex_mem_bundle[37];

   logic memop_s;
   logic illegal_s;
   logic misalign_s;
   logic timeout_hit_s;
   logic stall_s;

   assign memop_s   = ex_mem_valid & (mem_read_s ^ mem_write_s);
   assign illegal_s = ex_mem_valid & mem_read_s & mem_write_s;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s = (alu_result_s[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   // State and registered outputs
   state_e      state_q,     state_d;
   logic [15:0] cnt_q,       cnt_d;
   logic        req_q,       req_d;
   logic        we_q,        we_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic        hold_rw_q,   hold_rw_d;
   logic        hold_m2r_q,  hold_m2r_d;
   logic [31:0] hold_alu_q,  hold_alu_d;
   logic [4:0]  hold_dest_q, hold_dest_d;
   logic [70:0] wb_bundle_q, wb_bundle_d;
   logic        wb_valid_q,  wb_valid_d;
   logic        err_q,       err_d;

   assign timeout_hit_s = (state_q == ST_WAIT) & (cnt_q == TIMEOUT_LAST) & ~dmem_ack;

   // Next-state, memory request and MEM/WB bundle generation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      hold_rw_d   = hold_rw_q;
      hold_m2r_d  = hold_m2r_q;
      hold_alu_d  = hold_alu_q;
      hold_dest_d = hold_dest_q;
      wb_bundle_d = 71'd0;
      wb_valid_d  = 1'b0;
      err_d       = 1'b0;
      stall_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!ex_mem_valid) begin
               wb_bundle_d = 71'd0;
            end else if (illegal_s || (memop_s && misalign_s)) begin
               // rejected op: retire it without a register write
               err_d       = 1'b1;
               wb_valid_d  = 1'b1;
               wb_bundle_d = {1'b0, mem_to_reg_s, 32'd0, alu_result_s, reg_dest_s};
            end else if (memop_s) begin
               stall_s     = 1'b1;
               hold_rw_d   = reg_write_s;
               hold_m2r_d  = mem_to_reg_s;
               hold_alu_d  = alu_result_s;
               hold_dest_d = reg_dest_s;
               req_d       = 1'b1;
               we_d        = mem_write_s;
               addr_d      = {alu_result_s[31:2], 2'b00};
               wdata_d     = store_data_s;
               cnt_d       = 16'd0;
               state_d     = ST_WAIT;
            end else begin
               wb_valid_d  = 1'b1;
               wb_bundle_d = {reg_write_s, mem_to_reg_s, 32'd0, alu_result_s, reg_dest_s};
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (dmem_ack) begin
               // ack wins over a coincident timeout
               req_d       = 1'b0;
               state_d     = ST_IDLE;
               wb_valid_d  = 1'b1;
               wb_bundle_d = {hold_rw_q, hold_m2r_q, (we_q ? 32'd0 : dmem_rdata),
                              hold_alu_q, hold_dest_q};
            end else if (timeout_hit_s) begin
               req_d       = 1'b0;
               state_d     = ST_IDLE;
               err_d       = 1'b1;
               wb_valid_d  = 1'b1;
               wb_bundle_d = {1'b0, hold_m2r_q, 32'd0, hold_alu_q, hold_dest_q};
            end else begin
               stall_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'd0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         hold_rw_q   <= 1'b0;
         hold_m2r_q  <= 1'b0;
         hold_alu_q  <= 32'd0;
         hold_dest_q <= 5'd0;
         wb_bundle_q <= 71'd0;
         wb_valid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         hold_rw_q   <= hold_rw_d;
         hold_m2r_q  <= hold_m2r_d;
         hold_alu_q  <= hold_alu_d;
         hold_dest_q <= hold_dest_d;
         wb_bundle_q <= wb_bundle_d;
         wb_valid_q  <= wb_valid_d;
         err_q       <= err_d;
      end
   end

   assign stall         = stall_s;
   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign mem_wb_bundle = wb_bundle_q;
   assign mem_wb_valid  = wb_valid_q;
   assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage (TIMEOUT_CYCLES=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// on the falling edge.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic [74:0] bnd;
   logic        valid;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        ack;
   logic [31:0] rdata;
   logic [70:0] wb_bundle;
   logic        wb_valid;
   logic        mem_err;

   int n_cmp = 0;
   int n_bad = 0;
   int req_cnt;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_mem_bundle (bnd),
      .ex_mem_valid  (valid),
      .stall         (stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (ack),
      .dmem_rdata    (rdata),
      .mem_wb_bundle (wb_bundle),
      .mem_wb_valid  (wb_valid),
      .mem_err       (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [74:0] mk(input logic mr, input logic mw, input logic rw,
                                      input logic m2r, input logic [31:0] alu,
                                      input logic [31:0] sd, input logic [4:0] d);
      return {1'b0, mr, mw, rw, m2r, alu, 1'b0, sd, d};
   endfunction

   function automatic logic [70:0] wb(input logic rw, input logic m2r, input logic [31:0] rd,
                                      input logic [31:0] alu, input logic [4:0] d);
      return {rw, m2r, rd, alu, d};
   endfunction

   // Absolute guard against a hung run
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; valid = 1'b0; ack = 1'b0; rdata = 32'd0; bnd = 75'd0;
      tick(); tick();
      @(negedge clk);
      check("rst_req",   71'(dmem_req),   71'd0);
      check("rst_we",    71'(dmem_we),    71'd0);
      check("rst_addr",  71'(dmem_addr),  71'd0);
      check("rst_wdata", 71'(dmem_wdata), 71'd0);
      check("rst_wb",    wb_bundle,       71'd0);
      check("rst_wbv",   71'(wb_valid),   71'd0);
      check("rst_err",   71'(mem_err),    71'd0);
      tick();
      reset = 1'b0;

      // ALU op passes through in one cycle
      bnd = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5); valid = 1'b1;
      @(negedge clk); check("alu_stall", 71'(stall), 71'd0);
      tick(); valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("alu_wbv", 71'(wb_valid), 71'd1);
      check("alu_wb",  wb_bundle, wb(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5));
      check("alu_err", 71'(mem_err), 71'd0);
      tick();
      @(negedge clk); check("alu_wbv_once", 71'(wb_valid), 71'd0);
      tick();

      // Load with ack in the third wait cycle
      bnd = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7); valid = 1'b1;
      @(negedge clk);
      check("ld_stall_acc", 71'(stall), 71'd1);
      check("ld_req_acc",   71'(dmem_req), 71'd0);
      tick();
      req_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin ack = 1'b1; rdata = 32'hDEAD_BEEF; end
         @(negedge clk);
         if (dmem_req) req_cnt++;
         check("ld_addr",  71'(dmem_addr), 71'h100);
         check("ld_we",    71'(dmem_we), 71'd0);
         check("ld_stall", 71'(stall), 71'(i < 2));
         tick();
      end
      ack = 1'b0; valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("ld_req_cnt", 71'(req_cnt), 71'd3);
      check("ld_req_off", 71'(dmem_req), 71'd0);
      check("ld_wbv",     71'(wb_valid), 71'd1);
      check("ld_wb",      wb_bundle, wb(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd7));
      tick();

      // Store with immediate ack, then a back-to-back load
      bnd = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd3); valid = 1'b1;
      @(negedge clk); check("st_stall_acc", 71'(stall), 71'd1);
      tick();
      ack = 1'b1; rdata = 32'h5555_5555;
      @(negedge clk);
      check("st_req",   71'(dmem_req), 71'd1);
      check("st_we",    71'(dmem_we), 71'd1);
      check("st_addr",  71'(dmem_addr), 71'h200);
      check("st_wdata", 71'(dmem_wdata), 71'hCAFE_F00D);
      check("st_stall_ack", 71'(stall), 71'd0);
      tick();
      ack = 1'b0;
      bnd = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd9);
      @(negedge clk);
      check("st_wbv",    71'(wb_valid), 71'd1);
      check("st_wb",     wb_bundle, wb(1'b0, 1'b0, 32'h0, 32'h200, 5'd3));
      check("b2b_stall", 71'(stall), 71'd1);
      tick();
      @(negedge clk);
      check("b2b_req",  71'(dmem_req), 71'd1);
      check("b2b_addr", 71'(dmem_addr), 71'h300);
      check("b2b_we",   71'(dmem_we), 71'd0);
      check("b2b_wbv0", 71'(wb_valid), 71'd0);
      tick();
      ack = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk); check("b2b_stall_ack", 71'(stall), 71'd0);
      tick();
      ack = 1'b0; valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("b2b_wbv", 71'(wb_valid), 71'd1);
      check("b2b_wb",  wb_bundle, wb(1'b1, 1'b1, 32'h1111_2222, 32'h300, 5'd9));
      tick();

      // Illegal op: both mem_read and mem_write set
      bnd = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd6); valid = 1'b1;
      @(negedge clk); check("ill_stall", 71'(stall), 71'd0);
      tick(); valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("ill_err", 71'(mem_err), 71'd1);
      check("ill_wbv", 71'(wb_valid), 71'd1);
      check("ill_wb",  wb_bundle, wb(1'b0, 1'b0, 32'h0, 32'h40, 5'd6));
      check("ill_req", 71'(dmem_req), 71'd0);
      tick();
      @(negedge clk); check("ill_err_once", 71'(mem_err), 71'd0);
      tick();

      // Load never acked: aborts after 4 wait cycles
      bnd = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd4); valid = 1'b1;
      @(negedge clk); check("to_stall_acc", 71'(stall), 71'd1);
      tick();
      req_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (dmem_req) req_cnt++;
         if (!stall) break;
         tick();
      end
      tick();
      valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("to_req_cnt", 71'(req_cnt), 71'd4);
      check("to_req_off", 71'(dmem_req), 71'd0);
      check("to_err",     71'(mem_err), 71'd1);
      check("to_wbv",     71'(wb_valid), 71'd1);
      check("to_wb",      wb_bundle, wb(1'b0, 1'b1, 32'h0, 32'h400, 5'd4));
      tick();
      ack = 1'b1; rdata = 32'h9999_9999;
      @(negedge clk); check("late_ack_stall", 71'(stall), 71'd0);
      tick();
      ack = 1'b0;
      @(negedge clk);
      check("late_ack_wbv", 71'(wb_valid), 71'd0);
      check("late_ack_err", 71'(mem_err), 71'd0);
      check("late_ack_req", 71'(dmem_req), 71'd0);
      tick();

      // Reset during WAIT
      bnd = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0, 5'd1); valid = 1'b1;
      tick();
      @(negedge clk); check("rw_req_on", 71'(dmem_req), 71'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("rw_req",   71'(dmem_req), 71'd0);
      check("rw_addr",  71'(dmem_addr), 71'd0);
      check("rw_wdata", 71'(dmem_wdata), 71'd0);
      check("rw_wbv",   71'(wb_valid), 71'd0);
      check("rw_wb",    wb_bundle, 71'd0);
      check("rw_err",   71'(mem_err), 71'd0);
      check("rw_stall", 71'(stall), 71'd0);
      tick();
      bnd = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0ABC, 32'h0, 5'd2); valid = 1'b1;
      @(negedge clk); check("rw_alu_stall", 71'(stall), 71'd0);
      tick(); valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("rw_alu_wbv", 71'(wb_valid), 71'd1);
      check("rw_alu_wb",  wb_bundle, wb(1'b1, 1'b0, 32'h0, 32'hABC, 5'd2));
      tick();

      // Misaligned load address 0x102
      bnd = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd8); valid = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      @(negedge clk); check("mis_stall", 71'(stall), 71'd0);
      tick(); valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("mis_req", 71'(dmem_req), 71'd0);
      check("mis_err", 71'(mem_err), 71'd1);
      check("mis_wbv", 71'(wb_valid), 71'd1);
      check("mis_wb",  wb_bundle, wb(1'b0, 1'b1, 32'h0, 32'h102, 5'd8));
`else
      @(negedge clk); check("mis_stall", 71'(stall), 71'd1);
      tick();
      ack = 1'b1; rdata = 32'h7777_0000;
      @(negedge clk);
      check("mis_req",   71'(dmem_req), 71'd1);
      check("mis_addr",  71'(dmem_addr), 71'h100);
      check("mis_stall_ack", 71'(stall), 71'd0);
      tick();
      ack = 1'b0; valid = 1'b0; bnd = 75'd0;
      @(negedge clk);
      check("mis_err", 71'(mem_err), 71'd0);
      check("mis_wbv", 71'(wb_valid), 71'd1);
      check("mis_wb",  wb_bundle, wb(1'b1, 1'b1, 32'h7777_0000, 32'h102, 5'd8));
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
